nmr_compare_sm: RTL
===================

Name: nmr_compare_sm

Overview:
- Parametrised N-channel redundancy checker for the multi-core fault-tolerant fabric.
- Collects one 32-bit (DATA_W) result word per MicroBlaze core, each qualified by its own data_set flag.
- Compares the words and produces:
  - an all-match flag;
  - a majority-voted word;
  - a per-channel fault mask;
  - a saturating mismatch counter.
- Raises a level interrupt that stays high until acknowledged. The block then re-arms for the next round, with no reset required.

Parameters:
- NUM_CH, 3, number of redundant channels (2..4); NUM_CH=2 gives DWC behaviour.
- DATA_W, 32, width of each channel's data word.
- TIMEOUT, 1024, cycles allowed from first data_set to all data_set before forced compare (≥2).
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  NUM_CH*DATA_W  channel i word at bits [i*DATA_W +: DATA_W].
- data_set  in  NUM_CH  per-channel "word loaded" level flag, held high by the core.
- irq_ack  in  1  single-cycle acknowledge from the core that services the interrupt.
- all_match  out  1  every channel arrived and all words equal.
- vote_ok  out  1  a strict majority of channels agree.
- voted_data  out  DATA_W  majority word; 0 when vote_ok=0.
- fault_mask  out  NUM_CH  bit i=1: channel i missing or disagrees with the majority.
- timeout_flag  out  1  last compare was forced by timeout.
- err_count  out  CNT_W  saturating count of rounds with all_match=0.
- irq  out  1  interrupt request (level).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0 and all internal registers clear.
- States: IDLE, COLLECT, COMPARE, REPORT, WAIT_ACK, REARM.
- IDLE:
  - When any data_set bit is 1, go to COLLECT.
  - The timer clears to 0.
  - Channels whose data_set bit is high in that same cycle are captured.
- Capture rule (IDLE and COLLECT):
  - In the first cycle a channel's data_set is seen high while its arrived bit is 0, latch its word and set arrived[i].
  - Later changes on data_in for that channel are ignored.
  - A data_set bit that drops before compare does not clear arrived.
- COLLECT:
  - The timer increments each cycle.
  - If arrived is all ones, go to COMPARE with timeout_flag=0.
  - Otherwise, when the timer reaches TIMEOUT-1, go to COMPARE with timeout_flag=1.
  - If both conditions hold in the same cycle, the all-arrived path wins (timeout_flag=0).
- COMPARE (exactly 1 cycle); all outputs below are registered at the exit of this state:
  - Channel votes: for each arrived channel i, agree_i = number of arrived channels j (including i) with word_j == word_i.
  - vote_ok = 1 if any arrived i has 2*agree_i > NUM_CH.
  - voted_data = the word of the lowest-index channel satisfying that condition.
  - fault_mask, when vote_ok=1: bit i = !arrived[i] OR (word_i != voted_data).
  - fault_mask, when vote_ok=0: all ones.
  - all_match = arrived all ones AND every arrived word equal.
  - err_count increments by 1 when all_match=0; it holds at 2^CNT_W-1 (no wrap).
  - NUM_CH=2 with a disagreement gives vote_ok=0 and fault_mask=2'b11.
- REPORT: irq goes to 1 on entry; next cycle go to WAIT_ACK.
- WAIT_ACK:
  - irq stays 1 until irq_ack=1 is sampled.
  - On ack, irq=0 the next cycle and the state goes to REARM.
  - An irq_ack in any other state is ignored.
- REARM:
  - Wait until data_set is all zeros, then go to IDLE.
  - arrived and timer clear on the transition to IDLE.
  - Result outputs (all_match, vote_ok, voted_data, fault_mask, timeout_flag) hold until the next COMPARE; err_count persists until reset.
- Latency: from the cycle the last data_set arrives to irq=1 is 3 clk edges (capture, COMPARE, REPORT).
- Mid-operation reset: the round is abandoned, outputs clear and irq drops immediately (asynchronously).

Test Plan (NUM_CH=3, DATA_W=32, TIMEOUT=16, CNT_W=8):
- Equal words, all three data_set set in one cycle:
  - 0xA5A5_0001 on all channels → irq=1 on the 3rd edge.
  - all_match=1, vote_ok=1, voted_data=0xA5A5_0001, fault_mask=3'b000, err_count=0.
- Single-fault channel, flags staggered by 2 cycles:
  - ch1=0xDEAD_BEEF, ch0=ch2=0x1234_5678.
  - all_match=0, vote_ok=1, voted_data=0x1234_5678, fault_mask=3'b010, err_count=1.
- Timeout on a missing channel:
  - Only ch0 and ch2 set, both 0x55 → forced compare after 16 cycles in COLLECT.
  - timeout_flag=1, vote_ok=1, fault_mask=3'b010, all_match=0.
- No majority: words 1, 2, 3 → vote_ok=0, voted_data=0, fault_mask=3'b111.
- Ack and re-arm handshake:
  - irq holds through 10 idle cycles and drops the cycle after irq_ack.
  - With data_set held at 3'b111, busy stays 1 (REARM); clearing data_set gives IDLE, and a new round then runs.
- Reset and saturation:
  - Asserting reset while in COLLECT and WAIT_ACK clears irq/busy/err_count immediately.
  - CNT_W=2 with 5 mismatching rounds gives err_count=3.

Source files
------------

// File: rtl/nmr_compare_sm.sv
// nmr_compare_sm: N-channel redundancy checker. Latches one word per channel,
// votes them, and holds a level irq until it is acknowledged.
//
// state    | meaning
// IDLE     | no round in progress, waiting for the first data_set
// COLLECT  | capturing channels until all have arrived or the timer expires
// COMPARE  | one-cycle vote, results registered on exit
// REPORT   | irq just raised
// WAIT_ACK | irq held until irq_ack is sampled
// REARM    | waiting for every data_set to drop before the next round
module nmr_compare_sm #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*DATA_W-1:0]   data_in,
  input  logic [NUM_CH-1:0]          data_set,
  input  logic                       irq_ack,
  output logic                       all_match,
  output logic                       vote_ok,
  output logic [DATA_W-1:0]          voted_data,
  output logic [NUM_CH-1:0]          fault_mask,
  output logic                       timeout_flag,
  output logic [CNT_W-1:0]           err_count,
  output logic                       irq,
  output logic                       busy
);

  localparam int              TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [4:0]      CH_LIM   = 5'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_COMPARE, S_REPORT, S_WAIT_ACK, S_REARM
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_CH-1:0]          arrived_q, arrived_d;
  logic [NUM_CH*DATA_W-1:0]   words_q, words_d;
  logic [TMR_W-1:0]           tmr_q, tmr_d;
  logic                       forced_q, forced_d;
  logic                       all_match_q, all_match_d;
  logic                       vote_ok_q, vote_ok_d;
  logic [DATA_W-1:0]          voted_q, voted_d;
  logic [NUM_CH-1:0]          fmask_q, fmask_d;
  logic                       tflag_q, tflag_d;
  logic [CNT_W-1:0]           err_q, err_d;
  logic                       irq_q, irq_d;
  logic                       busy_q, busy_d;

  logic                       capture_en;
  logic [3:0]                 agree;
  logic                       cmp_vote;
  logic [DATA_W-1:0]          cmp_word;
  logic                       cmp_all;
  logic [NUM_CH-1:0]          cmp_fmask;

  // Vote over the latched words; only arrived channels take part.
  always_comb begin
    agree     = '0;
    cmp_vote  = 1'b0;
    cmp_word  = '0;
    cmp_all   = &arrived_q;
    cmp_fmask = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      agree = '0;
      for (int j = 0; j < NUM_CH; j++) begin
        if (arrived_q[j] && (words_q[j*DATA_W +: DATA_W] == words_q[i*DATA_W +: DATA_W])) begin
          agree = agree + 4'd1;
        end
      end
      if (arrived_q[i] && !cmp_vote && ({agree, 1'b0} > CH_LIM)) begin
        cmp_vote = 1'b1;
        cmp_word = words_q[i*DATA_W +: DATA_W];
      end
      if (arrived_q[i] && (words_q[i*DATA_W +: DATA_W] != words_q[DATA_W-1:0])) begin
        cmp_all = 1'b0;
      end
    end
    if (cmp_vote) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_fmask[i] = !arrived_q[i] || (words_q[i*DATA_W +: DATA_W] != cmp_word);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    arrived_d   = arrived_q;
    words_d     = words_q;
    tmr_d       = tmr_q;
    forced_d    = forced_q;
    all_match_d = all_match_q;
    vote_ok_d   = vote_ok_q;
    voted_d     = voted_q;
    fmask_d     = fmask_q;
    tflag_d     = tflag_q;
    err_d       = err_q;
    capture_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmr_d      = TMR_LOAD;
        capture_en = 1'b1;
        if (|data_set) begin
          state_d  = S_COLLECT;
          forced_d = 1'b0;
        end
      end
      S_COLLECT: begin
        capture_en = 1'b1;
        if (&arrived_q) begin
          state_d  = S_COMPARE;
          forced_d = 1'b0;
        end else if (tmr_q == '0) begin
          state_d  = S_COMPARE;
          forced_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_COMPARE: begin
        all_match_d = cmp_all;
        vote_ok_d   = cmp_vote;
        voted_d     = cmp_word;
        fmask_d     = cmp_fmask;
        tflag_d     = forced_q;
        if (!cmp_all && (err_q != '1)) begin
          err_d = err_q + CNT_W'(1);
        end
        state_d = S_REPORT;
      end
      S_REPORT: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (irq_ack) begin
          state_d = S_REARM;
        end
      end
      S_REARM: begin
        if (data_set == '0) begin
          state_d   = S_IDLE;
          arrived_d = '0;
          tmr_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A channel's word is frozen from the first cycle its flag is seen.
    if (capture_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (data_set[i] && !arrived_q[i]) begin
          arrived_d[i]                 = 1'b1;
          words_d[i*DATA_W +: DATA_W]  = data_in[i*DATA_W +: DATA_W];
        end
      end
    end

    irq_d  = (state_d == S_REPORT) || (state_d == S_WAIT_ACK);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      arrived_q   <= '0;
      words_q     <= '0;
      tmr_q       <= '0;
      forced_q    <= 1'b0;
      all_match_q <= 1'b0;
      vote_ok_q   <= 1'b0;
      voted_q     <= '0;
      fmask_q     <= '0;
      tflag_q     <= 1'b0;
      err_q       <= '0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arrived_q   <= arrived_d;
      words_q     <= words_d;
      tmr_q       <= tmr_d;
      forced_q    <= forced_d;
      all_match_q <= all_match_d;
      vote_ok_q   <= vote_ok_d;
      voted_q     <= voted_d;
      fmask_q     <= fmask_d;
      tflag_q     <= tflag_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
    end
  end

  assign all_match    = all_match_q;
  assign vote_ok      = vote_ok_q;
  assign voted_data   = voted_q;
  assign fault_mask   = fmask_q;
  assign timeout_flag = tflag_q;
  assign err_count    = err_q;
  assign irq          = irq_q;
  assign busy         = busy_q;

endmodule
